// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl
// Description : Single-clock FIFO controller driving a single-port RAM; owns
//               pointers, occupancy and status flags, one RAM op per cycle.
//               Optional macro FIFO_CTRL_STICKY_ERR_EN makes err sticky.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_DEPTH  = 8,
    parameter int AF_TH      = 6,
    parameter int AE_TH      = 1
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  push_stall,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic                  mem_valid_out,
    input  logic                  mem_err
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_PTR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   C_DEPTH    = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic                  w_pop_grant;
    logic                  w_push_grant;
    logic                  w_err_event;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Pop wins over push so the RAM never sees a read and write together.
    assign w_pop_grant  = pop & ~empty;
    assign w_push_grant = push & ~full & ~w_pop_grant;
    assign push_stall   = push & ~w_push_grant;
    assign w_err_event  = (push & full) | (pop & empty) | mem_err;

    assign pop_data  = mem_data_out;
    assign pop_valid = mem_valid_out;

    always_comb begin
        w_count_nxt = count;
        if (w_pop_grant) begin
            w_count_nxt = count - 1'b1;
        end else if (w_push_grant) begin
            w_count_nxt = count + 1'b1;
        end
    end

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(input logic [ADDR_WIDTH-1:0] ptr);
        return (ptr == C_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
        end else begin
            mem_write <= w_push_grant;
            mem_read  <= w_pop_grant;
            if (w_pop_grant) begin
                mem_address <= r_rd_ptr;
                r_rd_ptr    <= next_ptr(r_rd_ptr);
            end else if (w_push_grant) begin
                mem_address <= r_wr_ptr;
                mem_data    <= push_data;
                r_wr_ptr    <= next_ptr(r_wr_ptr);
            end
        end
    end

    // Flags come from the next count so they line up with the new occupancy.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= (AE_TH >= 0);
        end else begin
            count        <= w_count_nxt;
            full         <= (w_count_nxt == C_DEPTH);
            empty        <= (w_count_nxt == '0);
            almost_full  <= (int'(w_count_nxt) >= AF_TH);
            almost_empty <= (int'(w_count_nxt) <= AE_TH);
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            err <= 1'b0;
        end else begin
`ifdef FIFO_CTRL_STICKY_ERR_EN
            err <= err | w_err_event;
`else
            err <= w_err_event;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
`default_nettype none
// Testbench for fifo_ctrl: behavioural RAM plus a queue-based FIFO reference,
// scenario tasks with inline comparisons and a randomized traffic phase.
module tb_fifo_ctrl;

    localparam int DW    = 6;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          RESET_L = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          mem_err = 1'b0;
    logic [DW-1:0] push_data = '0;

    logic          push_stall;
    logic [DW-1:0] pop_data;
    logic          pop_valid;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data;
    logic          mem_write, mem_read;
    logic [DW-1:0] ram_out;
    logic          ram_valid;
    logic [DW-1:0] ram [DEPTH];

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk          (clk),
        .RESET_L      (RESET_L),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .push_stall   (push_stall),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .err          (err),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_data_out (ram_out),
        .mem_valid_out(ram_valid),
        .mem_err      (mem_err)
    );

    // Single-port RAM: registered read data and valid, shares RESET_L.
    always @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            ram_valid <= 1'b0;
            ram_out   <= '0;
        end else begin
            ram_valid <= mem_read;
            if (mem_read) ram_out <= ram[mem_address];
            if (mem_write) ram[mem_address] <= mem_data;
        end
    end

    // Reference model state
    logic [DW-1:0] mq[$];
    bit            v1, v2;
    logic [DW-1:0] dd1, dd2;
    bit            exp_wr, exp_rd, exp_err, exp_stall, obs_stall;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_mdata;
    int            total_push, total_pop;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic model_reset;
        mq.delete();
        v1 = 0; v2 = 0; dd1 = '0; dd2 = '0;
        exp_wr = 0; exp_rd = 0; exp_err = 0; exp_stall = 0;
        exp_addr = '0; exp_mdata = '0;
        total_push = 0; total_pop = 0;
    endtask

    // Called at a negedge; applies inputs for one cycle and advances the model.
    task automatic drive(input bit p, input bit o, input logic [DW-1:0] d);
        bit pg, wg, ev;
        int sz;
        push = p; pop = o; push_data = d;
        sz = mq.size();
        pg = o && (sz != 0);
        wg = p && (sz != DEPTH) && !pg;
        exp_stall = p && !wg;
        ev = (p && sz == DEPTH) || (o && sz == 0) || (mem_err === 1'b1);
        #1 obs_stall = push_stall;
        @(posedge clk);
        v2 = v1; dd2 = dd1; v1 = pg;
        if (pg) begin
            dd1 = mq.pop_front();
            exp_addr = AW'(total_pop % DEPTH);
            total_pop++;
        end
        if (wg) begin
            mq.push_back(d);
            exp_addr = AW'(total_push % DEPTH);
            exp_mdata = d;
            total_push++;
        end
        exp_wr = wg; exp_rd = pg;
`ifdef FIFO_CTRL_STICKY_ERR_EN
        exp_err = exp_err || ev;
`else
        exp_err = ev;
`endif
        @(negedge clk);
    endtask

    task automatic test_reset;
        RESET_L = 1'b0; push = 0; pop = 0; mem_err = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({pop_valid, mem_write, mem_read, err} !== 4'b0000)
            $display("FAIL reset_hold: got pv/mw/mr/err=%b%b%b%b exp 0000", pop_valid, mem_write, mem_read, err);
        else n_pass++;
        RESET_L = 1'b1;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({full, empty, almost_full, almost_empty} !== 4'b0101)
            $display("FAIL reset_flags: got f/e/af/ae=%b%b%b%b exp 0101", full, empty, almost_full, almost_empty);
        else n_pass++;
        n_checks++;
        if (count !== 4'd0) $display("FAIL reset_count: got %0d exp 0", count);
        else n_pass++;
        n_checks++;
        if ({err, mem_write, mem_read} !== 3'b000 || {mem_address, mem_data} !== 9'h0)
            $display("FAIL reset_mem: got err/mw/mr=%b%b%b addr=%0d data=%h exp all 0",
                     err, mem_write, mem_read, mem_address, mem_data);
        else n_pass++;
    endtask

    task automatic test_fill_drain;
        bit ev;
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1, 0, DW'(i));
            n_checks++;
            if (obs_stall !== 1'b0 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_data !== DW'(i))
                $display("FAIL fill_write[%0d]: got stall=%b mw=%b mr=%b data=%h exp 0 1 0 %h",
                         i, obs_stall, mem_write, mem_read, mem_data, DW'(i));
            else n_pass++;
            n_checks++;
            if (count !== 4'(i) || almost_full !== (i >= AF))
                $display("FAIL fill_count[%0d]: got count=%0d af=%b exp %0d %b", i, count, almost_full, i, (i >= AF));
            else n_pass++;
        end
        n_checks++;
        if (full !== 1'b1) $display("FAIL fill_full: got %b exp 1", full);
        else n_pass++;
        for (int i = 1; i <= DEPTH + 2; i++) begin
            drive(0, i <= DEPTH, '0);
            ev = (i >= 2) && (i <= DEPTH + 1);
            n_checks++;
            if (pop_valid !== ev || (ev && pop_data !== DW'(i - 1)))
                $display("FAIL drain_data[%0d]: got valid=%b data=%h exp %b %h", i, pop_valid, pop_data, ev, DW'(i - 1));
            else n_pass++;
        end
        n_checks++;
        if (empty !== 1'b1 || count !== 4'd0) $display("FAIL drain_empty: got empty=%b count=%0d exp 1 0", empty, count);
        else n_pass++;
    endtask

    task automatic test_priority;
        for (int i = 0; i < 3; i++) drive(1, 0, DW'(6'h21 + i));
        drive(1, 1, 6'h3F);
        n_checks++;
        if (obs_stall !== 1'b1) $display("FAIL prio_stall: got %b exp 1", obs_stall);
        else n_pass++;
        n_checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || count !== 4'd2)
            $display("FAIL prio_grant: got mr=%b mw=%b count=%0d exp 1 0 2", mem_read, mem_write, count);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(0, i < 2, '0);
            n_checks++;
            if (pop_valid !== v2 || (v2 && pop_data !== dd2))
                $display("FAIL prio_drain[%0d]: got valid=%b data=%h exp %b %h", i, pop_valid, pop_data, v2, dd2);
            else n_pass++;
        end
    endtask

    task automatic test_wrap;
        logic [DW-1:0] got[$];
        logic [AW-1:0] prev_waddr;
        bit wrap_seen;
        wrap_seen = 0;
        prev_waddr = '0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, DW'(6'h10 + i));
            if (pop_valid === 1'b1) got.push_back(pop_data);
            n_checks++;
            if (mem_write !== 1'b1 || mem_address !== exp_addr || count > 4'd2)
                $display("FAIL wrap_write[%0d]: got mw=%b addr=%0d count=%0d exp 1 %0d <=2",
                         i, mem_write, mem_address, count, exp_addr);
            else n_pass++;
            if (i > 0 && prev_waddr == 3'd7 && mem_address == 3'd0) wrap_seen = 1;
            prev_waddr = mem_address;
            drive(0, 1, '0);
            if (pop_valid === 1'b1) got.push_back(pop_data);
        end
        repeat (2) begin
            drive(0, 0, '0);
            if (pop_valid === 1'b1) got.push_back(pop_data);
        end
        n_checks++;
        if (!wrap_seen) $display("FAIL wrap_addr: got no 7->0 write address wrap exp wrap");
        else n_pass++;
        n_checks++;
        if (got.size() != 12) $display("FAIL wrap_count: got %0d words exp 12", got.size());
        else n_pass++;
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            n_checks++;
            if (got[i] !== DW'(6'h10 + i)) $display("FAIL wrap_data[%0d]: got %h exp %h", i, got[i], DW'(6'h10 + i));
            else n_pass++;
        end
    endtask

    task automatic test_overflow_underflow;
        bit sticky;
`ifdef FIFO_CTRL_STICKY_ERR_EN
        sticky = 1;
`else
        sticky = 0;
`endif
        for (int i = 0; i < DEPTH; i++) drive(1, 0, DW'($urandom));
        drive(1, 0, 6'h2A);
        n_checks++;
        if (count !== 4'd8 || mem_write !== 1'b0 || err !== 1'b1 || obs_stall !== 1'b1)
            $display("FAIL overflow: got count=%0d mw=%b err=%b stall=%b exp 8 0 1 1", count, mem_write, err, obs_stall);
        else n_pass++;
        drive(0, 0, '0);
        n_checks++;
        if (err !== sticky) $display("FAIL overflow_err_after: got %b exp %b", err, sticky);
        else n_pass++;
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(0, i < DEPTH, '0);
            n_checks++;
            if (pop_valid !== v2 || (v2 && pop_data !== dd2))
                $display("FAIL ovf_drain[%0d]: got valid=%b data=%h exp %b %h", i, pop_valid, pop_data, v2, dd2);
            else n_pass++;
        end
        drive(0, 1, '0);
        n_checks++;
        if (mem_read !== 1'b0 || err !== 1'b1 || count !== 4'd0)
            $display("FAIL underflow: got mr=%b err=%b count=%0d exp 0 1 0", mem_read, err, count);
        else n_pass++;
        drive(0, 0, '0);
        n_checks++;
        if (err !== sticky || pop_valid !== 1'b0)
            $display("FAIL underflow_after: got err=%b pv=%b exp %b 0", err, pop_valid, sticky);
        else n_pass++;
        mem_err = 1'b1;
        drive(0, 0, '0);
        mem_err = 1'b0;
        n_checks++;
        if (err !== 1'b1) $display("FAIL mem_err: got %b exp 1", err);
        else n_pass++;
        drive(0, 0, '0);
        n_checks++;
        if (err !== sticky) $display("FAIL mem_err_after: got %b exp %b", err, sticky);
        else n_pass++;
    endtask

    task automatic test_random;
        bit p, o;
        for (int c = 0; c < 300; c++) begin
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            drive(p, o, DW'($urandom));
            n_checks++;
            if (obs_stall !== exp_stall) $display("FAIL rnd_stall[%0d]: got %b exp %b", c, obs_stall, exp_stall);
            else n_pass++;
            n_checks++;
            if (count !== 4'(mq.size()) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0) ||
                almost_full !== (mq.size() >= AF) || almost_empty !== (mq.size() <= AE))
                $display("FAIL rnd_status[%0d]: got count=%0d f/e/af/ae=%b%b%b%b exp count=%0d",
                         c, count, full, empty, almost_full, almost_empty, mq.size());
            else n_pass++;
            n_checks++;
            if (mem_write !== exp_wr || mem_read !== exp_rd || mem_address !== exp_addr || mem_data !== exp_mdata)
                $display("FAIL rnd_mem[%0d]: got mw=%b mr=%b addr=%0d data=%h exp %b %b %0d %h",
                         c, mem_write, mem_read, mem_address, mem_data, exp_wr, exp_rd, exp_addr, exp_mdata);
            else n_pass++;
            n_checks++;
            if (err !== exp_err) $display("FAIL rnd_err[%0d]: got %b exp %b", c, err, exp_err);
            else n_pass++;
            n_checks++;
            if (pop_valid !== v2 || (v2 && pop_data !== dd2))
                $display("FAIL rnd_pop[%0d]: got valid=%b data=%h exp %b %h", c, pop_valid, pop_data, v2, dd2);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset;
        drive(1, 0, 6'h15);
        drive(1, 0, 6'h16);
        drive(0, 1, '0);
        n_checks++;
        if (mem_read !== 1'b1) $display("FAIL midrst_pre: got mr=%b exp 1", mem_read);
        else n_pass++;
        RESET_L = 1'b0;
        #1;
        n_checks++;
        if ({pop_valid, mem_write, mem_read, err, full, empty, almost_full, almost_empty} !== 8'b0000_0101 ||
            count !== 4'd0 || {mem_address, mem_data} !== 9'h0)
            $display("FAIL midrst_outputs: got pv/mw/mr/err=%b%b%b%b f/e/af/ae=%b%b%b%b count=%0d addr=%0d data=%h exp reset values",
                     pop_valid, mem_write, mem_read, err, full, empty, almost_full, almost_empty, count, mem_address, mem_data);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (pop_valid !== 1'b0) $display("FAIL midrst_valid[%0d]: got %b exp 0", i, pop_valid);
            else n_pass++;
        end
        RESET_L = 1'b1;
        model_reset();
        push = 0; pop = 0;
        @(negedge clk);
        n_checks++;
        if (empty !== 1'b1 || count !== 4'd0 || pop_valid !== 1'b0)
            $display("FAIL midrst_after: got empty=%b count=%0d pv=%b exp 1 0 0", empty, count, pop_valid);
        else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_drain();
        test_priority();
        test_wrap();
        test_overflow_underflow();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fifo_ctrl.md
# fifo_ctrl

Single-clock FIFO controller that sits directly upstream of the single-port `mem` RAM block. It owns the read/write pointers and the occupancy count, and converts producer push and consumer pop requests into `mem` address/write/read strobes. It routes the RAM's read data and valid back to the consumer and reports full/empty/threshold status and errors. One RAM operation is issued per cycle; read and write are never issued together.

## Interface
- `DATA_WIDTH`, 6: word width; must match `mem`.
- `ADDR_WIDTH`, 3: address width; must match `mem`.
- `RAM_DEPTH`, 8: number of entries, 2..2^ADDR_WIDTH, not necessarily a power of two.
- `AF_TH`, 6: `almost_full` asserts when count >= AF_TH.
- `AE_TH`, 1: `almost_empty` asserts when count <= AE_TH.

Ports:
- `clk` input 1: the block's single clock.
- `RESET_L` input 1: reset, asynchronous and active-low.
- `push` input 1: producer write request.
- `push_data` input DATA_WIDTH: write word.
- `pop` input 1: consumer read request.
- `push_stall` output 1: combinational; push not accepted this cycle, producer must hold.
- `pop_data` output DATA_WIDTH: `mem_data_out`, passed through.
- `pop_valid` output 1: `mem_valid_out`, passed through.
- `full`, `empty`, `almost_full`, `almost_empty` output 1 each: registered status flags.
- `count` output ADDR_WIDTH+1: registered occupancy, 0..RAM_DEPTH.
- `err` output 1: registered error flag.
- `mem_address` output ADDR_WIDTH: registered, to RAM `address`.
- `mem_data` output DATA_WIDTH: registered, to RAM `data`.
- `mem_write`, `mem_read` output 1 each: registered, to RAM `write` and `read`.
- `mem_data_out` input DATA_WIDTH, `mem_valid_out` input 1, `mem_err` input 1: from RAM.

## Operation
- **Grant (evaluated each posedge):**
  - pop_grant = `pop` & ~`empty`.
  - push_grant = `push` & ~`full` & ~pop_grant. Pop has priority when both are requested.
  - `push_stall` = `push` & ~push_grant.
- **pop_grant:**
  - `mem_read` <= 1, `mem_address` <= rd_ptr.
  - rd_ptr advances.
  - count decrements.
- **push_grant:**
  - `mem_write` <= 1, `mem_address` <= wr_ptr, `mem_data` <= `push_data`.
  - wr_ptr advances.
  - count increments.
- **No grant:** `mem_write` <= 0, `mem_read` <= 0. Address and data hold.
- **Pointers:** ADDR_WIDTH bits. Pointer RAM_DEPTH-1 wraps to 0.
- **Status flags:** recomputed from the next count value at the same edge, so they are valid in the cycle after the grant.
  - `full` = (count == RAM_DEPTH).
  - `empty` = (count == 0).
- **Errors (error event):**
  - overflow: `push` & `full`.
  - underflow: `pop` & `empty`.
  - RAM error: `mem_err`.
  - Overflow and underflow requests are dropped: no RAM access, no pointer or count change.
- **Invariant:** `mem_write` & `mem_read` is never 1.

## Timing
- **Reset values** (asynchronous on `RESET_L` low):
  - pointers 0, `count` 0.
  - `empty` 1, `almost_empty` 1 (AE_TH >= 0), `full` 0, `almost_full` 0.
  - `err` 0.
  - `mem_write`, `mem_read`, `mem_address`, `mem_data` all 0.
- **Write latency:** grant at edge N. `mem_write` is high in cycle N+1. Data is stored at edge N+1.
- **Read latency:** grant at edge N. `mem_read` is high in cycle N+1. `pop_valid`/`pop_data` are valid in cycle N+2, for exactly one cycle per granted pop.
- **Read after write to the same entry:** a pop granted at edge N+1, right after a push granted at edge N, returns the new word.
- **Back-to-back pops:** one `pop_valid` per cycle, in FIFO order.
- **Wrap-around:** exercised continuously at any RAM_DEPTH, with no bubble.
- **Reset mid-operation:** in-flight reads are discarded. `mem` shares `RESET_L`, so `pop_valid` is 0 from reset assertion.

## Configuration
- **Macro `FIFO_CTRL_STICKY_ERR_EN`.**
- **Defined:** `err` sets on any error event and stays 1 until `RESET_L`.
- **Undefined:** `err` is a one-cycle registered pulse in the cycle after each error event.

## Test plan
All scenarios use default parameters.
- **Reset:** hold `RESET_L`=0, then release. Required: `empty`=1, `almost_empty`=1, `count`=0, `err`=0, `mem_write`=`mem_read`=0.
- **Fill and drain:**
  - Push 8 words 0x01..0x08. Required: `full`=1, `count`=8, `almost_full` rises when count reaches 6.
  - Then pop 8. Required: `pop_data` 0x01..0x08 in order, each valid 2 cycles after its pop edge; `empty`=1 at the end.
- **Priority:** count=3, assert `push`=`pop`=1 for one cycle. Required:
  - `push_stall`=1.
  - `mem_read`=1 and `mem_write`=0 next cycle.
  - count becomes 2.
- **Wrap:** 12 interleaved push/pop pairs of 0x10..0x1B with occupancy ≤ 2. Required: all words returned in order; addresses wrap 7→0.
- **Overflow and underflow:**
  - Push when full. Required: count stays 8, no `mem_write`, `err` set.
  - Pop when empty. Required: no `mem_read`, `err` set.
  - Check `err` both with and without `FIFO_CTRL_STICKY_ERR_EN`: sticky when defined, one-cycle pulse when undefined.
- **Mid-operation reset:** assert `RESET_L`=0 one cycle after a pop grant. Required: no `pop_valid`; all outputs at reset values.
